// File: rtl/uart_defs_pkg.sv
// uart_defs_pkg: UART state encodings, default oversampling ratio and the
// even-parity definition shared by the receiver and the transmitter.
package uart_defs_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;
  // Even parity: XOR of data and parity bit is 0 on a good frame.
  function automatic logic even_parity(input logic [15:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-FF synchronizer with a configurable reset value.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sync_q <= {2{RST_VAL}};
    else sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver on a 16x oversample tick, with framing-error flag.
// Define UART_RX_PARITY_EN to add an even-parity bit and o_Parity_Err.
module uart_rx
  import uart_defs_pkg::*;
#(
  parameter int Bits       = 8,
  parameter int SB_TICK    = 16,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic            i_Clock,
  input  logic            i_reset,
  input  logic            i_bd,
  input  logic            i_Rx_Serial,
  output logic [Bits-1:0] o_Rx_Byte,
  output logic            o_Rx_Done,
  output logic            o_Rx_Active,
  output logic            o_Frame_Err,
  output logic            o_Parity_Err
);
  localparam int TW = $clog2(OVERSAMPLE > SB_TICK ? OVERSAMPLE : SB_TICK);
  localparam int BW = $clog2(Bits) + 1;
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = RX_PARITY;
`else
  localparam rx_state_e AFTER_DATA = RX_STOP;
`endif
  rx_state_e       state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [Bits-1:0] shift_q, shift_d, byte_q, byte_d;
  logic            done_q, done_d, ferr_q, ferr_d, rx_s;
  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i(i_Clock), .rst_i(i_reset), .d_i(i_Rx_Serial), .q_o(rx_s)
  );
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
`endif
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      RX_IDLE: begin
        tick_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: if (i_bd) begin
        tick_d = (tick_q == T_HALF) ? '0 : tick_q + TW'(1);
        bit_d  = '0;
        if (tick_q == T_HALF) state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (i_bd) begin
        tick_d = (tick_q == T_BIT) ? '0 : tick_q + TW'(1);
        if (tick_q == T_BIT) begin
          shift_d = {rx_s, shift_q[Bits-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == BW'(Bits - 1)) state_d = AFTER_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: if (i_bd) begin
        tick_d = (tick_q == T_BIT) ? '0 : tick_q + TW'(1);
        if (tick_q == T_BIT) begin
          par_d   = rx_s;
          state_d = RX_STOP;
        end
      end
`endif
      RX_STOP: if (i_bd) begin
        tick_d = (tick_q == T_STOP) ? '0 : tick_q + TW'(1);
        if (tick_q == T_STOP) begin
          done_d  = 1'b1;
          byte_d  = shift_q;
          ferr_d  = !rx_s;
`ifdef UART_RX_PARITY_EN
          perr_d  = even_parity(16'(shift_q)) ^ par_q;
`endif
          state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      // A held-low line must return high before a new start edge is accepted.
      RX_WAIT_HIGH: if (rx_s) state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge i_Clock or posedge i_reset)
    if (i_reset) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  assign o_Rx_Byte   = byte_q;
  assign o_Rx_Done   = done_q;
  assign o_Rx_Active = state_q != RX_IDLE;
  assign o_Frame_Err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = perr_q;
`else
  assign o_Parity_Err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-frame bench for uart_rx; i_bd every 4 clocks, 64 clocks per bit.
module tb_uart_rx;
  logic       clk = 1'b0, rst = 1'b1, bd = 1'b0, rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_done, rx_active, frame_err, parity_err;
  logic [1:0] bd_cnt = '0;
  int         n_chk = 0, n_pass = 0;
  int         cyc = 0, last_bd = 0, last_gap = 0, done_cnt = 0, cnt0;
  logic       saw_active = 1'b0;

  uart_rx dut (
    .i_Clock(clk), .i_reset(rst), .i_bd(bd), .i_Rx_Serial(rx),
    .o_Rx_Byte(rx_byte), .o_Rx_Done(rx_done), .o_Rx_Active(rx_active),
    .o_Frame_Err(frame_err), .o_Parity_Err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    bd_cnt = bd_cnt + 2'd1;
    bd = (bd_cnt == 2'd0);
  end

  always @(posedge clk) begin
    cyc++;
    if (rx_done) begin
      done_cnt++;
      last_gap = cyc - last_bd;
    end
    if (rx_active) saw_active = 1'b1;
    if (bd) last_bd = cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(p);
`else
    if (p !== p) send_bit(1'b0);
`endif
    send_bit(stop);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_byte", 32'(rx_byte), 32'h00);
    check("rst_done", 32'(rx_done), 32'h0);
    check("rst_active", 32'(rx_active), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    repeat (640) @(negedge clk);
    check("idle_active", 32'(saw_active), 32'h0);
    check("idle_done", 32'(done_cnt), 32'd0);

    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1);
    check("a5_count", 32'(done_cnt), 32'd1);
    check("a5_byte", 32'(rx_byte), 32'hA5);
    check("a5_ferr", 32'(frame_err), 32'h0);
    check("a5_latency", 32'(last_gap), 32'd1);
    check("a5_idle", 32'(rx_active), 32'h0);

    saw_active = 1'b0;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    send_bit(1'b1);
    send_bit(1'b1);
    check("glitch_active", 32'(saw_active), 32'h1);
    check("glitch_count", 32'(done_cnt), 32'd1);
    check("glitch_byte", 32'(rx_byte), 32'hA5);
    check("glitch_idle", 32'(rx_active), 32'h0);

    send_frame(8'h3C, 1'b0, 1'b0);
    check("brk_count", 32'(done_cnt), 32'd2);
    check("brk_byte", 32'(rx_byte), 32'h3C);
    check("brk_ferr", 32'(frame_err), 32'h1);
    repeat (160) @(negedge clk);
    check("brk_hold_count", 32'(done_cnt), 32'd2);
    check("brk_hold_active", 32'(rx_active), 32'h1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("brk_release", 32'(rx_active), 32'h0);
    send_frame(8'h55, 1'b0, 1'b1);
    check("r55_count", 32'(done_cnt), 32'd3);
    check("r55_byte", 32'(rx_byte), 32'h55);
    check("r55_ferr", 32'(frame_err), 32'h0);

    send_frame(8'h00, 1'b0, 1'b1);
    check("b2b_00_byte", 32'(rx_byte), 32'h00);
    send_frame(8'hFF, 1'b0, 1'b1);
    check("b2b_ff_byte", 32'(rx_byte), 32'hFF);
    check("b2b_count", 32'(done_cnt), 32'd5);

    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    saw_active = 1'b0;
    cnt0 = done_cnt;
    check("abort_byte", 32'(rx_byte), 32'h00);
    check("abort_active", 32'(rx_active), 32'h0);
    check("abort_ferr", 32'(frame_err), 32'h0);
    check("abort_done", 32'(rx_done), 32'h0);
    repeat (640) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(cnt0));
    check("abort_quiet", 32'(saw_active), 32'h0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1);
    check("par_good_byte", 32'(rx_byte), 32'h07);
    check("par_good_perr", 32'(parity_err), 32'h0);
    send_frame(8'h07, 1'b0, 1'b1);
    send_bit(1'b1);
    check("par_bad_perr", 32'(parity_err), 32'h1);
    check("par_bad_ferr", 32'(frame_err), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
